// File: rtl/proc_pkg.sv
// ============================================================
// proc_pkg : shared opcodes, field positions and FSM states
// Rev 1.0
// ============================================================
`default_nettype none

package proc_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] OP_SETX = 5'b10101;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [4:0] REG_STATUS = 5'd30;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int ALU_MSB = 6;
  localparam int ALU_LSB = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    MD_RUN = 1'b1
  } md_state_t;

endpackage

`default_nettype wire

// File: rtl/src_decode.sv
// ============================================================
// src_decode : source-register and class decode of one instruction
// Rev 1.0
// ============================================================
`default_nettype none

module src_decode
  import proc_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_src_a,
  output logic [4:0]  o_src_b,
  output logic        o_uses_src_b,
  output logic        o_is_branch,
  output logic        o_writes_rd
);

  logic [4:0] w_op;
  logic [4:0] w_rd;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_unused_bits;

  assign w_op = i_instr[OPC_MSB:OPC_LSB];
  assign w_rd = i_instr[RD_MSB:RD_LSB];
  assign w_rs = i_instr[RS_MSB:RS_LSB];
  assign w_rt = i_instr[RT_MSB:RT_LSB];
  assign w_unused_bits = ^i_instr[11:0];

  always_comb begin
    o_src_a      = w_rs;
    o_src_b      = 5'd0;
    o_uses_src_b = 1'b0;
    o_is_branch  = 1'b0;
    o_writes_rd  = 1'b0;
    case (w_op)
      OP_R: begin
        o_src_b      = w_rt;
        o_uses_src_b = 1'b1;
        o_writes_rd  = 1'b1;
      end
      OP_SW: begin
        o_src_b      = w_rd;
        o_uses_src_b = 1'b1;
      end
      OP_BNE, OP_BLT, OP_JR: begin
        o_src_b      = w_rd;
        o_uses_src_b = 1'b1;
        o_is_branch  = 1'b1;
      end
      // bex tests the status register implicitly
      OP_BEX: begin
        o_src_b      = REG_STATUS;
        o_uses_src_b = 1'b1;
        o_is_branch  = 1'b1;
      end
      OP_LW, OP_ADDI, OP_JAL, OP_SETX: begin
        o_writes_rd  = 1'b1;
      end
      default: begin
        o_src_b      = 5'd0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================
// hazard_ctrl : stall/bubble/flush scheduling and multdiv sequencing
// Rev 1.0
// ============================================================
`default_nettype none

module hazard_ctrl
  import proc_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 40,
  parameter int STALL_CNT_W   = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [31:0]            InstrFD,
  input  logic [31:0]            InstrDX,
  input  logic [31:0]            InstrXM,
  input  logic                   branch_taken,
  input  logic                   md_ready,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   stall_x,
  output logic                   bubble_dx,
  output logic                   bubble_xm,
  output logic                   flush_fd,
  output logic                   md_start_mult,
  output logic                   md_start_div,
  output logic                   md_busy,
  output logic                   md_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int                  MD_CNT_W = $clog2(MD_MAX_CYCLES);
  localparam logic [MD_CNT_W-1:0] MD_LAST  = MD_CNT_W'(MD_MAX_CYCLES - 1);

  logic [4:0]          w_fd_src_a;
  logic [4:0]          w_fd_src_b;
  logic                w_fd_uses_b;
  logic                w_fd_is_branch;
  logic                w_fd_writes_rd;

  logic [4:0]          w_dx_op;
  logic [4:0]          w_dx_rd;
  logic [4:0]          w_dx_alu;
  logic [4:0]          w_xm_op;
  logic [4:0]          w_xm_rd;
  logic                w_dx_is_lw;
  logic                w_xm_is_lw;
  logic                w_dx_is_mul;
  logic                w_dx_is_div;
  logic                w_dx_hit;
  logic                w_xm_hit;
  logic                w_lu;
  logic                w_bl;
  logic                w_ld_stall;
  logic                w_unused_bits;

  md_state_t           r_state;
  md_state_t           w_next_state;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [MD_CNT_W-1:0] w_md_cnt_nxt;
  logic                w_md_hold;
  logic                w_start_mult;
  logic                w_start_div;
  logic                w_timeout;

  logic [STALL_CNT_W-1:0] r_stall_count;

  src_decode u_fd_decode (
    .i_instr      (InstrFD),
    .o_src_a      (w_fd_src_a),
    .o_src_b      (w_fd_src_b),
    .o_uses_src_b (w_fd_uses_b),
    .o_is_branch  (w_fd_is_branch),
    .o_writes_rd  (w_fd_writes_rd)
  );

  assign w_dx_op  = InstrDX[OPC_MSB:OPC_LSB];
  assign w_dx_rd  = InstrDX[RD_MSB:RD_LSB];
  assign w_dx_alu = InstrDX[ALU_MSB:ALU_LSB];
  assign w_xm_op  = InstrXM[OPC_MSB:OPC_LSB];
  assign w_xm_rd  = InstrXM[RD_MSB:RD_LSB];

  assign w_unused_bits = ^{InstrDX[21:7], InstrDX[1:0], InstrXM[21:0], w_fd_writes_rd};

  assign w_dx_is_lw  = (w_dx_op == OP_LW);
  assign w_xm_is_lw  = (w_xm_op == OP_LW);
  assign w_dx_is_mul = (w_dx_op == OP_R) && (w_dx_alu == ALU_MUL);
  assign w_dx_is_div = (w_dx_op == OP_R) && (w_dx_alu == ALU_DIV);

  // r0 is hardwired, so a zero destination can never feed a source
  assign w_dx_hit = (w_dx_rd != 5'd0) &&
                    ((w_dx_rd == w_fd_src_a) || (w_fd_uses_b && (w_dx_rd == w_fd_src_b)));
  assign w_xm_hit = (w_xm_rd != 5'd0) &&
                    ((w_xm_rd == w_fd_src_a) || (w_fd_uses_b && (w_xm_rd == w_fd_src_b)));

  assign w_lu = w_dx_is_lw & w_dx_hit;
  assign w_bl = w_fd_is_branch & w_xm_is_lw & w_xm_hit;

  assign w_ld_stall = (w_lu | w_bl) & ~w_md_hold;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_next_state;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_md_hold    = 1'b0;
    w_start_mult = 1'b0;
    w_start_div  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dx_is_mul || w_dx_is_div) begin
          w_start_mult = w_dx_is_mul;
          w_start_div  = w_dx_is_div;
          w_md_hold    = 1'b1;
          w_next_state = MD_RUN;
          w_md_cnt_nxt = '0;
        end
      end
      MD_RUN: begin
        // Releasing in the ready/timeout cycle lets the op leave DX on this edge
        if (md_ready) begin
          w_next_state = IDLE;
          w_md_cnt_nxt = '0;
        end else if (r_md_cnt == MD_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
          w_md_cnt_nxt = '0;
        end else begin
          w_md_hold    = 1'b1;
          w_md_cnt_nxt = r_md_cnt + MD_CNT_W'(1);
        end
      end
      default: begin
        w_next_state = IDLE;
        w_md_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, regardless of latch contents
  assign stall_f       = reset_n & (w_md_hold | w_ld_stall);
  assign stall_d       = reset_n & (w_md_hold | w_ld_stall);
  assign stall_x       = reset_n & w_md_hold;
  assign bubble_dx     = reset_n & w_ld_stall;
  assign bubble_xm     = reset_n & w_md_hold;
  assign flush_fd      = reset_n & branch_taken & ~(w_md_hold | w_ld_stall);
  assign md_start_mult = reset_n & w_start_mult;
  assign md_start_div  = reset_n & w_start_div;
  assign md_busy       = reset_n & (r_state == MD_RUN);
  assign md_timeout    = reset_n & w_timeout;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= '0;
    end else if (stall_f && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + STALL_CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================
// tb_hazard_ctrl : directed checks of hazard_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

module tb_hazard_ctrl;

  // {stall_f, stall_d, stall_x, bubble_dx, bubble_xm, flush_fd,
  //  md_start_mult, md_start_div, md_busy, md_timeout}
  localparam logic [9:0] O_NONE   = 10'b0000000000;
  localparam logic [9:0] O_LU     = 10'b1101000000;
  localparam logic [9:0] O_FLUSH  = 10'b0000010000;
  localparam logic [9:0] O_MSTART = 10'b1110101000;
  localparam logic [9:0] O_DSTART = 10'b1110100100;
  localparam logic [9:0] O_MRUN   = 10'b1110100010;
  localparam logic [9:0] O_REL    = 10'b0000000010;
  localparam logic [9:0] O_TMO    = 10'b0000000011;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] r_fd;
  logic [31:0] r_dx;
  logic [31:0] r_xm;
  logic        r_branch_taken;
  logic        r_md_ready;

  logic        w_stall_f, w_stall_d, w_stall_x, w_bubble_dx, w_bubble_xm;
  logic        w_flush_fd, w_start_mult, w_start_div, w_busy, w_timeout;
  logic [31:0] w_count;
  logic        s_stall_f, s_stall_d, s_stall_x, s_bubble_dx, s_bubble_xm;
  logic        s_flush_fd, s_start_mult, s_start_div, s_busy, s_timeout;
  logic [1:0]  s_count;
  logic [9:0]  w_outs;
  logic [9:0]  s_outs;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hazard_ctrl #(.MD_MAX_CYCLES(40), .STALL_CNT_W(32)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .InstrFD(r_fd), .InstrDX(r_dx), .InstrXM(r_xm),
    .branch_taken(r_branch_taken), .md_ready(r_md_ready),
    .stall_f(w_stall_f), .stall_d(w_stall_d), .stall_x(w_stall_x),
    .bubble_dx(w_bubble_dx), .bubble_xm(w_bubble_xm), .flush_fd(w_flush_fd),
    .md_start_mult(w_start_mult), .md_start_div(w_start_div),
    .md_busy(w_busy), .md_timeout(w_timeout), .stall_count(w_count)
  );

  hazard_ctrl #(.MD_MAX_CYCLES(40), .STALL_CNT_W(2)) u_dut_sat (
    .clock(clock), .reset_n(reset_n),
    .InstrFD(r_fd), .InstrDX(r_dx), .InstrXM(r_xm),
    .branch_taken(r_branch_taken), .md_ready(r_md_ready),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_x(s_stall_x),
    .bubble_dx(s_bubble_dx), .bubble_xm(s_bubble_xm), .flush_fd(s_flush_fd),
    .md_start_mult(s_start_mult), .md_start_div(s_start_div),
    .md_busy(s_busy), .md_timeout(s_timeout), .stall_count(s_count)
  );

  assign w_outs = {w_stall_f, w_stall_d, w_stall_x, w_bubble_dx, w_bubble_xm,
                   w_flush_fd, w_start_mult, w_start_div, w_busy, w_timeout};
  assign s_outs = {s_stall_f, s_stall_d, s_stall_x, s_bubble_dx, s_bubble_xm,
                   s_flush_fd, s_start_mult, s_start_div, s_busy, s_timeout};

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] alu);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    r_fd           = '0;
    r_dx           = enc_r(5'd3, 5'd1, 5'd2, 5'b00110);
    r_xm           = '0;
    r_branch_taken = 1'b1;
    r_md_ready     = 1'b0;
    #3;
    chk("rst_outs", w_outs, O_NONE);
    chk("rst_count", w_count, 0);
    tick();
    r_dx = '0;
    r_branch_taken = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1 chk("idle", w_outs, O_NONE);

    // load-use on rs, rt and sw data register
    tick(); r_dx = enc_i(5'b01000, 5'd5, 5'd1, 17'd0); r_fd = enc_r(5'd1, 5'd5, 5'd2, 5'd0);
    #1 chk("lu_rs", w_outs, O_LU); chk("cnt_0", w_count, 0);
    tick(); r_xm = r_dx; r_dx = '0;
    #1 chk("lu_release", w_outs, O_NONE); chk("cnt_1", w_count, 1);
    tick(); r_xm = '0; r_dx = enc_i(5'b01000, 5'd5, 5'd1, 17'd0); r_fd = enc_r(5'd1, 5'd2, 5'd5, 5'd0);
    #1 chk("lu_rt", w_outs, O_LU);
    tick(); r_fd = enc_i(5'b00111, 5'd5, 5'd2, 17'd0);
    #1 chk("lu_sw", w_outs, O_LU);
    tick(); r_dx = enc_i(5'b01000, 5'd0, 5'd1, 17'd0); r_fd = enc_r(5'd1, 5'd0, 5'd0, 5'd0);
    #1 chk("lw_r0", w_outs, O_NONE);
    tick(); r_dx = enc_i(5'b01000, 5'd5, 5'd1, 17'd0); r_fd = enc_i(5'b00101, 5'd1, 5'd2, 17'h05000);
    #1 chk("addi_no_srcb", w_outs, O_NONE); chk("cnt_3", w_count, 3);

    // branch flush, then load-use followed by branch-load
    tick(); r_dx = '0; r_fd = enc_i(5'b00010, 5'd7, 5'd3, 17'd0); r_branch_taken = 1'b1;
    #1 chk("flush_plain", w_outs, O_FLUSH);
    tick(); r_dx = enc_i(5'b01000, 5'd7, 5'd1, 17'd0);
    #1 chk("lu_bne", w_outs, O_LU);
    tick(); r_xm = r_dx; r_dx = '0;
    #1 chk("bl_bne", w_outs, O_LU);
    tick(); r_xm = '0;
    #1 chk("flush_after", w_outs, O_FLUSH); chk("cnt_5", w_count, 5);
    tick(); r_branch_taken = 1'b0; r_xm = enc_i(5'b01000, 5'd30, 5'd1, 17'd0);
    r_fd = enc_i(5'b10110, 5'd0, 5'd0, 17'd0);
    #1 chk("bl_bex", w_outs, O_LU);
    tick(); r_fd = enc_r(5'd1, 5'd30, 5'd2, 5'd0);
    #1 chk("xm_lw_nonbranch", w_outs, O_NONE);

    // mul with md_ready on the 5th MD_RUN cycle
    tick(); r_xm = '0; r_fd = '0; r_dx = enc_r(5'd3, 5'd1, 5'd2, 5'b00110);
    #1 chk("mul_start", w_outs, O_MSTART);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 2) begin
        r_xm = enc_i(5'b01000, 5'd5, 5'd1, 17'd0);
        r_fd = enc_i(5'b00010, 5'd5, 5'd0, 17'd0);
      end
      if (i == 3) begin
        r_xm = '0; r_fd = '0; r_branch_taken = 1'b1;
      end
      #1 chk("mul_run", w_outs, O_MRUN);
    end
    tick(); r_branch_taken = 1'b0; r_md_ready = 1'b1;
    #1 chk("mul_ready", w_outs, O_REL); chk("cnt_11", w_count, 11);

    // back-to-back mul, then md_ready while idle
    tick(); r_md_ready = 1'b0; r_dx = enc_r(5'd4, 5'd3, 5'd1, 5'b00110);
    #1 chk("b2b_start", w_outs, O_MSTART);
    tick(); r_md_ready = 1'b1;
    #1 chk("b2b_ready", w_outs, O_REL);
    tick(); r_dx = '0;
    #1 chk("ready_in_idle", w_outs, O_NONE);
    tick(); r_md_ready = 1'b0;
    #1 chk("idle_after", w_outs, O_NONE); chk("cnt_12", w_count, 12);

    // div that never completes: watchdog fires on MD_RUN cycle 40
    tick(); r_dx = enc_r(5'd5, 5'd1, 5'd2, 5'b00111);
    #1 chk("div_start", w_outs, O_DSTART);
    for (int i = 1; i <= 39; i++) begin
      tick();
      #1 chk("div_run", w_outs, O_MRUN);
    end
    tick();
    #1 chk("div_timeout", w_outs, O_TMO); chk("cnt_52", w_count, 52);
    chk("sat_count", s_count, 3);
    tick(); r_dx = '0;
    #1 chk("div_idle", w_outs, O_NONE);

    // reset during MD_RUN, then the pending mul restarts
    tick(); r_dx = enc_r(5'd3, 5'd1, 5'd2, 5'b00110);
    #1 chk("rst_mul_start", w_outs, O_MSTART);
    tick();
    #1 chk("rst_mul_run", w_outs, O_MRUN);
    reset_n = 1'b0;
    #1 chk("rst_mid_outs", w_outs, O_NONE); chk("rst_mid_count", w_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 chk("rst_restart", w_outs, O_MSTART);
    tick(); r_md_ready = 1'b1;
    #1 chk("rst_ready", w_outs, O_REL);
    tick(); r_md_ready = 1'b0; r_dx = '0;
    #1 chk("rst_idle", w_outs, O_NONE); chk("rst_cnt_1", w_count, 1);
    chk("sat_outs", s_outs, O_NONE); chk("sat_cnt_1", s_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
